// File: rtl/cups_pkg.sv
// Shared types and constants for the three-cup pouring datapath and its sequencer.
package cups_pkg;

  typedef enum logic [1:0] {
    LARGE  = 2'd0,
    MEDIUM = 2'd1,
    SMALL  = 2'd2
  } Cup;

  localparam int unsigned CAP_L = 12;
  localparam int unsigned CAP_M = 8;
  localparam int unsigned CAP_S = 5;

  localparam logic [1:0] FAIL_NONE      = 2'd0;
  localparam logic [1:0] FAIL_EXHAUSTED = 2'd1;
  localparam logic [1:0] FAIL_ILLEGAL   = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_CHECK  = 3'd3,
    S_SOLVED = 3'd4,
    S_FAIL   = 3'd5
  } sched_state_e;

  // One pour move; all-zero is the no-op (LARGE into LARGE).
  typedef struct packed {
    logic [1:0] src;
    logic [1:0] dst;
  } move_t;

  // Capacity of a cup code; invalid code reports zero.
  function automatic logic [3:0] cup_cap(input logic [1:0] c);
    case (c)
      2'd0:    cup_cap = 4'(CAP_L);
      2'd1:    cup_cap = 4'(CAP_M);
      2'd2:    cup_cap = 4'(CAP_S);
      default: cup_cap = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/pour_sched_if.sv
// Host/datapath-facing bundle of the pour sequencer.
interface pour_sched_if;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [1:0] prog_from;
  logic [1:0] prog_to;
  logic [4:0] prog_len;
  logic       start;
  logic [3:0] large_lvl;
  logic [3:0] medium_lvl;
  logic [3:0] small_lvl;
  logic [1:0] from;
  logic [1:0] to;
  logic       busy;
  logic       solved;
  logic       failed;
  logic [1:0] fail_code;
  logic [4:0] step;

  modport master (
    output prog_we, prog_addr, prog_from, prog_to, prog_len, start,
    output large_lvl, medium_lvl, small_lvl,
    input  from, to, busy, solved, failed, fail_code, step
  );

  modport slave (
    input  prog_we, prog_addr, prog_from, prog_to, prog_len, start,
    input  large_lvl, medium_lvl, small_lvl,
    output from, to, busy, solved, failed, fail_code, step
  );
endinterface

// File: rtl/pour_move_table.sv
// Move table: DEPTH x 4-bit register file, one write port, combinational read.
module pour_move_table
  import cups_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       we,
  input  logic [3:0] waddr,
  input  move_t      wdata,
  input  logic [3:0] raddr,
  output move_t      rdata
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  move_t mem [DEPTH];

  // Storage; reset fills every entry with the no-op, out-of-range writes drop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (we && ({1'b0, waddr} < 5'(DEPTH))) begin
      mem[waddr[AW-1:0]] <= wdata;
    end
  end

  // Read port; out-of-range indices return the no-op.
  always_comb begin
    rdata = '0;
    if ({1'b0, raddr} < 5'(DEPTH)) rdata = mem[raddr[AW-1:0]];
  end

endmodule

// File: rtl/pour_sched.sv
// Move sequencer for the three-cup pouring datapath.
// Optional: define POUR_SCHED_LEGAL_CHECK_EN to reject illegal moves before issue.
module pour_sched
  import cups_pkg::*;
#(
  parameter int unsigned MAX_STEPS = 16,
  parameter int unsigned TGT_L     = 6,
  parameter int unsigned TGT_M     = 6
) (
  input  logic         clock,
  input  logic         reset,
  pour_sched_if.slave  bus
);

  sched_state_e state;
  logic [4:0]   len_q;
  logic [4:0]   step_q;

  logic         idle_c;
  logic         tbl_we_c;
  logic         goal_c;
  logic         last_c;
  logic [3:0]   rd_idx_c;
  move_t        wr_mv_c;
  move_t        rd_mv_c;
  move_t        nxt_mv_c;
  move_t        iss_mv_c;

  assign idle_c   = (state == S_IDLE) || (state == S_SOLVED) || (state == S_FAIL);
  assign tbl_we_c = bus.prog_we && idle_c;
  assign wr_mv_c  = {bus.prog_from, bus.prog_to};
  assign rd_idx_c = (state == S_CHECK) ? 4'(step_q + 5'd1) : 4'd0;
  assign goal_c   = (bus.large_lvl == 4'(TGT_L)) && (bus.medium_lvl == 4'(TGT_M));
  assign last_c   = (5'(step_q + 5'd1) == len_q);

  pour_move_table #(.DEPTH(MAX_STEPS)) u_table (
    .clock (clock),
    .reset (reset),
    .we    (tbl_we_c),
    .waddr (bus.prog_addr),
    .wdata (wr_mv_c),
    .raddr (rd_idx_c),
    .rdata (rd_mv_c)
  );

  // A write landing on the entry about to be issued wins over the stored copy.
  assign nxt_mv_c = (tbl_we_c && (bus.prog_addr == rd_idx_c)) ? wr_mv_c : rd_mv_c;

`ifdef POUR_SCHED_LEGAL_CHECK_EN
  logic illegal_c;
  logic illegal_q;

  function automatic logic [3:0] lvl_of(input logic [1:0] c);
    case (c)
      2'd0:    lvl_of = bus.large_lvl;
      2'd1:    lvl_of = bus.medium_lvl;
      2'd2:    lvl_of = bus.small_lvl;
      default: lvl_of = 4'd0;
    endcase
  endfunction

  // Levels are stable from CHECK through the following ISSUE, so judging the
  // move one edge early gives the same verdict and keeps from/to registered.
  always_comb begin
    illegal_c = (nxt_mv_c.src == 2'd3) || (nxt_mv_c.dst == 2'd3) ||
                (nxt_mv_c.src == nxt_mv_c.dst) ||
                (lvl_of(nxt_mv_c.src) == 4'd0) ||
                (lvl_of(nxt_mv_c.dst) >= cup_cap(nxt_mv_c.dst));
  end

  assign iss_mv_c = illegal_c ? move_t'('0) : nxt_mv_c;
`else
  assign iss_mv_c = nxt_mv_c;
`endif

  // Sequencer FSM with registered outputs; from/to default to the no-op.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      len_q         <= '0;
      step_q        <= '0;
      bus.from      <= '0;
      bus.to        <= '0;
      bus.busy      <= 1'b0;
      bus.solved    <= 1'b0;
      bus.failed    <= 1'b0;
      bus.fail_code <= FAIL_NONE;
`ifdef POUR_SCHED_LEGAL_CHECK_EN
      illegal_q     <= 1'b0;
`endif
    end else begin
      bus.from <= '0;
      bus.to   <= '0;
      case (state)
        S_IDLE, S_SOLVED, S_FAIL: begin
          if (bus.start) begin
            len_q         <= bus.prog_len;
            step_q        <= '0;
            bus.solved    <= 1'b0;
            bus.failed    <= 1'b0;
            bus.fail_code <= FAIL_NONE;
            if (bus.prog_len == 5'd0) begin
              state         <= S_FAIL;
              bus.failed    <= 1'b1;
              bus.fail_code <= FAIL_EXHAUSTED;
              bus.busy      <= 1'b0;
            end else begin
              state    <= S_ISSUE;
              bus.busy <= 1'b1;
              bus.from <= iss_mv_c.src;
              bus.to   <= iss_mv_c.dst;
`ifdef POUR_SCHED_LEGAL_CHECK_EN
              illegal_q <= illegal_c;
`endif
            end
          end
        end
        S_ISSUE: begin
`ifdef POUR_SCHED_LEGAL_CHECK_EN
          if (illegal_q) begin
            state         <= S_FAIL;
            bus.failed    <= 1'b1;
            bus.fail_code <= FAIL_ILLEGAL;
            bus.busy      <= 1'b0;
          end else begin
            state <= S_WAIT;
          end
`else
          state <= S_WAIT;
`endif
        end
        S_WAIT: state <= S_CHECK;
        S_CHECK: begin
          if (goal_c) begin
            state      <= S_SOLVED;
            bus.solved <= 1'b1;
            bus.busy   <= 1'b0;
          end else if (last_c) begin
            state         <= S_FAIL;
            bus.failed    <= 1'b1;
            bus.fail_code <= FAIL_EXHAUSTED;
            bus.busy      <= 1'b0;
          end else begin
            state    <= S_ISSUE;
            step_q   <= 5'(step_q + 5'd1);
            bus.from <= iss_mv_c.src;
            bus.to   <= iss_mv_c.dst;
`ifdef POUR_SCHED_LEGAL_CHECK_EN
            illegal_q <= illegal_c;
`endif
          end
        end
        default: begin
          state    <= S_IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

  assign bus.step = step_q;

endmodule

// File: tb/tb_pour_sched.sv
// Bench for pour_sched with a behavioural cups datapath and a result scoreboard.
module tb_pour_sched;
  import cups_pkg::*;

  typedef struct {
    int cyc;
    int sol;
    int fl;
    int code;
    int stp;
    int l;
    int m;
    int s;
    int f0;
    int t0;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic dp_clr = 1'b0;
  logic [3:0] lv_l, lv_m, lv_s;
  logic [1:0] lat_f, lat_t;
  exp_t exp_q[$];
  int n_chk = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  pour_sched_if bus ();

  pour_sched #(.MAX_STEPS(16), .TGT_L(6), .TGT_M(6)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.large_lvl  = lv_l;
  assign bus.medium_lvl = lv_m;
  assign bus.small_lvl  = lv_s;

  // Pour a latched move: amount is min(source, free space in destination).
  function automatic logic [11:0] pour_fn(input logic [3:0] l, m, s, input logic [1:0] f, t);
    int lv[3];
    int cap[3];
    int amt;
    lv  = '{int'(l), int'(m), int'(s)};
    cap = '{12, 8, 5};
    if (f != t && f < 2'd3 && t < 2'd3) begin
      amt = cap[t] - lv[t];
      if (lv[f] < amt) amt = lv[f];
      lv[f] = lv[f] - amt;
      lv[t] = lv[t] + amt;
    end
    return {4'(lv[0]), 4'(lv[1]), 4'(lv[2])};
  endfunction

  // Datapath model: latch move at one edge, pour it at the next.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      {lv_l, lv_m, lv_s} <= {4'd12, 4'd0, 4'd0};
      {lat_f, lat_t}     <= 4'd0;
    end else if (dp_clr) begin
      {lv_l, lv_m, lv_s} <= {4'd12, 4'd0, 4'd0};
      {lat_f, lat_t}     <= 4'd0;
    end else begin
      {lv_l, lv_m, lv_s} <= pour_fn(lv_l, lv_m, lv_s, lat_f, lat_t);
      {lat_f, lat_t}     <= {bus.from, bus.to};
    end
  end

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic push(input int cyc, sol, fl, code, stp, l, m, s, f0, t0);
    exp_t e;
    e = '{cyc, sol, fl, code, stp, l, m, s, f0, t0};
    exp_q.push_back(e);
  endtask

  task automatic prog(input int a, input int f, input int t);
    @(negedge clock);
    bus.prog_we   = 1'b1;
    bus.prog_addr = 4'(a);
    bus.prog_from = 2'(f);
    bus.prog_to   = 2'(t);
    @(negedge clock);
    bus.prog_we   = 1'b0;
  endtask

  task automatic dp_clear();
    @(negedge clock);
    dp_clr = 1'b1;
    @(negedge clock);
    dp_clr = 1'b0;
  endtask

  // Start a run in cycle 0, wait for solved/failed, then compare against the scoreboard.
  task automatic run(input int len, input int poke, input string tag);
    int cyc;
    int done;
    int f0;
    int t0;
    exp_t e;
    @(negedge clock);
    bus.prog_len = 5'(len);
    bus.start    = 1'b1;
    cyc = 0; done = 0; f0 = -1; t0 = -1;
    while (done == 0 && cyc < 200) begin
      @(posedge clock);
      #1;
      cyc++;
      bus.start   = 1'b0;
      bus.prog_we = 1'b0;
      if (cyc == 1) begin
        f0 = int'(bus.from);
        t0 = int'(bus.to);
      end
      if (bus.solved || bus.failed) done = 1;
      else if (cyc == poke) begin
        bus.prog_we   = 1'b1;
        bus.prog_addr = 4'd0;
        bus.prog_from = 2'd2;
        bus.prog_to   = 2'd0;
        bus.start     = 1'b1;
      end
    end
    e = exp_q.pop_front();
    check({tag, ".done"},  done, 1);
    check({tag, ".cycle"}, cyc, e.cyc);
    check({tag, ".solved"}, int'(bus.solved), e.sol);
    check({tag, ".failed"}, int'(bus.failed), e.fl);
    check({tag, ".code"},  int'(bus.fail_code), e.code);
    check({tag, ".busy"},  int'(bus.busy), 0);
    check({tag, ".step"},  int'(bus.step), e.stp);
    check({tag, ".lvl"},   int'({lv_l, lv_m, lv_s}), (e.l << 8) | (e.m << 4) | e.s);
    check({tag, ".from0"}, f0, e.f0);
    check({tag, ".to0"},   t0, e.t0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".from"},   int'(bus.from), 0);
    check({tag, ".to"},     int'(bus.to), 0);
    check({tag, ".busy"},   int'(bus.busy), 0);
    check({tag, ".solved"}, int'(bus.solved), 0);
    check({tag, ".failed"}, int'(bus.failed), 0);
    check({tag, ".code"},   int'(bus.fail_code), 0);
    check({tag, ".step"},   int'(bus.step), 0);
  endtask

  initial begin
    int busy_seen;
    bus.prog_we   = 1'b0;
    bus.prog_addr = 4'd0;
    bus.prog_from = 2'd0;
    bus.prog_to   = 2'd0;
    bus.prog_len  = 5'd0;
    bus.start     = 1'b0;
    repeat (2) @(negedge clock);
    check_reset_vals("rst0");
    reset = 1'b0;

    // 7-move solution: L>M, M>S, S>L, M>S, L>M, M>S, S>L
    prog(0, 0, 1); prog(1, 1, 2); prog(2, 2, 0); prog(3, 1, 2);
    prog(4, 0, 1); prog(5, 1, 2); prog(6, 2, 0);

    dp_clear();
    push(22, 1, 0, 0, 6, 6, 6, 0, 0, 1);
    run(7, -1, "solve7");

    dp_clear();
    push(10, 0, 1, 1, 2, 9, 3, 0, 0, 1);
    run(3, -1, "len3");

    // Empty program: fails at once, busy never rises; levels left from the prior run.
    busy_seen = 0;
    push(1, 0, 1, 1, 0, 9, 3, 0, 0, 0);
    fork
      run(0, -1, "len0");
      repeat (4) begin
        @(posedge clock); #2;
        if (bus.busy) busy_seen = 1;
      end
    join
    check("len0.busy_seen", busy_seen, 0);

    // Writes and start while busy are ignored; run matches the clean solve.
    dp_clear();
    push(22, 1, 0, 0, 6, 6, 6, 0, 0, 1);
    run(7, 4, "busy_ign");

    // Entry 0 = M>S with the medium cup empty.
    prog(0, 1, 2);
    dp_clear();
`ifdef POUR_SCHED_LEGAL_CHECK_EN
    push(2, 0, 1, 2, 0, 12, 0, 0, 0, 0);
`else
    push(4, 0, 1, 1, 0, 12, 0, 0, 1, 2);
`endif
    run(1, -1, "illegal");

    // Reset mid-run in cycle 5, then rerun on the cleared table.
    prog(0, 0, 1);
    dp_clear();
    @(negedge clock);
    bus.prog_len = 5'd7;
    bus.start    = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clock);
    #2;
    check("pre_rst.busy", int'(bus.busy), 1);
    reset = 1'b1;
    #1;
    check_reset_vals("rst_mid");
    @(negedge clock);
    reset = 1'b0;
`ifdef POUR_SCHED_LEGAL_CHECK_EN
    push(2, 0, 1, 2, 0, 12, 0, 0, 0, 0);
`else
    push(49, 0, 1, 1, 15, 12, 0, 0, 0, 0);
`endif
    run(16, -1, "rst16");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pour_sched.md
# pour_sched

Move sequencer for the three-cup pouring datapath (`cups`). It holds a programmable table of up to 16 pour moves and issues them one at a time on the datapath's `from`/`to` inputs. It waits out the datapath's two-stage latch-then-pour latency, then checks the returned cup levels for the 6/6 goal. It reports solved, sequence exhausted, or illegal move, and sits between a host/testbench and the `cups` instance.

## Interface
Parameters:
- `MAX_STEPS`, 16: move-table depth; must be a power of two, at most 16.
- `TGT_L`, 6: goal level for the large cup.
- `TGT_M`, 6: goal level for the medium cup.

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state including the table.
- `prog_we` in 1: table write strobe; ignored while `busy`.
- `prog_addr` in 4: table entry index.
- `prog_from` in 2: source cup code for the entry.
- `prog_to` in 2: destination cup code for the entry.
- `prog_len` in 5: number of valid entries, 0..MAX_STEPS; sampled when `start` is accepted.
- `start` in 1: begin execution; accepted only in IDLE.
- `large_lvl`, `medium_lvl`, `small_lvl` in 4 each: current levels from the datapath.
- `from`, `to` out 2 each: move driven to the datapath.
- `busy` out 1: high in every state except IDLE, SOLVED and FAIL.
- `solved` out 1: goal reached; sticky until the next accepted `start` or `reset`.
- `failed` out 1: run ended without reaching the goal; sticky until the next accepted `start` or `reset`.
- `fail_code` out 2: reason for failure. 0 = none, 1 = exhausted, 2 = illegal move, 3 = reserved.
- `step` out 5: index of the current or last move.

## Operation
- Cup codes: LARGE=0, MEDIUM=1, SMALL=2. Code 3 is invalid.
- No-op: `from == to == LARGE`. The datapath performs no pour when source equals destination. `from`/`to` carry the no-op in every state except ISSUE.
- FSM states: IDLE, ISSUE, WAIT, CHECK, SOLVED, FAIL.
- IDLE:
  - On `start`: latch `prog_len`, set `step`=0, clear `solved`, `failed` and `fail_code`.
  - Then go to FAIL with code 1 if `prog_len`==0, otherwise go to ISSUE.
- ISSUE:
  - Read `entry[step]` and drive it on `from`/`to` for exactly this one cycle.
  - Go to WAIT.
  - Illegal entries are handled per Configuration.
- WAIT: one dead cycle while the datapath latches the move and then pours. Go to CHECK.
- CHECK:
  - If `large_lvl==TGT_L && medium_lvl==TGT_M`, go to SOLVED.
  - Otherwise, if `step+1 == len`, go to FAIL with code 1.
  - Otherwise increment `step` and go to ISSUE.
- SOLVED and FAIL:
  - Hold until `start`, which re-enters the IDLE start path in the same edge.
  - `busy`=0 in both.
- Table writes: accepted only in IDLE, SOLVED or FAIL. `prog_addr >= MAX_STEPS` is ignored.
- Reset values:
  - state IDLE.
  - `from`=`to`=0.
  - `busy`=0, `solved`=0, `failed`=0, `fail_code`=0, `step`=0.
  - All table entries = no-op.
- Reset mid-run: the sequencer returns to IDLE immediately. The datapath is not reset by this block; the host resets both together.
- `start` while `busy`: ignored.
- `start` in the same cycle as `prog_we`: both take effect. The run uses the old table content for that address only if step 0 reads it in the same edge, which it cannot. The new entry is therefore used.

## Timing
- A move is driven in ISSUE, cycle n.
- The datapath latches it at the end of cycle n and pours at the end of cycle n+1.
- Levels are valid in cycle n+2, which is CHECK.
- Three cycles per move.
- With `start` sampled at the end of cycle 0, move k is driven in cycle 3k+1.
- `solved`/`failed` are registered and rise in cycle 3k+4 after a CHECK of move k.
- The illegal-move FAIL rises in the cycle after the offending ISSUE, with no move issued.

## Configuration
- `POUR_SCHED_LEGAL_CHECK_EN` defined: in ISSUE, an entry is illegal if any of the following holds:
  - either code is 3;
  - `from==to`;
  - the source level is 0;
  - the destination is at capacity (L=12, M=8, S=5).
- An illegal entry drives the no-op, sets `fail_code`=2 and goes to FAIL.
- Macro undefined: entries are issued blindly. A self-pour or code 3 acts as a no-op step, and `fail_code` is never 2.

## Structure
- `cups_pkg`:
  - `Cup` enum with LARGE/MEDIUM/SMALL.
  - Capacity constants CAP_L=12, CAP_M=8, CAP_S=5.
  - Fail-code constants and FSM state typedef.
  - Shared with `cups`.
- Sub-module `pour_move_table`: MAX_STEPS x 4-bit register file with async reset, one write port and one combinational read port.

## Test plan
- Program the 7-move solution L>M, M>S, S>L, M>S, L>M, M>S, S>L with `prog_len`=7 and `start` in cycle 0.
  - Levels pass through 4/8/0, 4/3/5, 9/3/0, 9/0/3, 1/8/3, 1/6/5, 6/6/0.
  - `solved`=1 in cycle 22, `busy`=0, `step`=6.
- Run the first 3 moves only with `prog_len`=3 → `failed`=1, `fail_code`=1 in cycle 10, levels 9/3/0.
- With the macro on, make entry 0 M>S at initial levels 12/0/0 → no move issued, `failed`=1, `fail_code`=2 in cycle 2.
- Start with `prog_len`=0 → `failed`=1, `fail_code`=1, `busy` never asserted.
- Assert `reset` in cycle 5 of the 7-move run → all outputs at their reset values asynchronously and the table cleared. A new `start` without reprogramming fails with code 2 if the macro is on, or code 1 after 16 no-op steps if it is off, with `prog_len`=16.
- Assert `prog_we` and `start` while `busy` → both ignored, and the run completes as in the first test.
